a7_ddr3_wr_ctrl: RTL and testbench
==================================

A7_DDR3_WR_CTRL -- requirements
Module: a7_ddr3_wr_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- sclk  input  1: the only clock; all state changes on its rising edge.
- rst  input  1: synchronous reset, active-high.
REQ-002 wr_cmd_start  input  1: one-cycle pulse that requests a write burst.
REQ-003 wr_cmd_bl  input  7: burst length in 128-bit beats, sampled with wr_cmd_start; 0 is illegal and ignored.
REQ-004 wr_cmd_addr  input  28: start address, sampled with wr_cmd_start.
REQ-005 wr_data_128bit  input  128: write data, valid in the same cycle wr_data_req is high (FWFT FIFO head).
REQ-006 wr_data_req  output  1: beat-accept strobe, used as the read enable of the user FWFT FIFO.
REQ-007 wr_busy  output  1: burst in progress (state != IDLE).
REQ-008 wr_end  output  1: one-cycle pulse when a burst completes.
REQ-009 wr_err  output  1: one-cycle pulse when a burst is aborted by timeout; tied 0 when the timeout feature is compiled out.
REQ-010 MIG-side ports:
- app_rdy  input  1
- app_wdf_rdy  input  1
- app_en  output  1
- app_addr  output  28
- app_cmd  output  3
- app_wdf_wren  output  1
- app_wdf_data  output  128
- app_wdf_end  output  1
- app_wdf_mask  output  16

Function
REQ-011 The state machine SHALL have three states, IDLE, WRITE and DONE, with these transitions:
- IDLE -> WRITE on wr_cmd_start=1 with wr_cmd_bl!=0.
- WRITE -> DONE on the fire of the last beat.
- DONE -> IDLE unconditionally after 1 cycle.
REQ-012 On the accepted start, the block SHALL latch wr_cmd_bl into cmd_bl, load the address register with wr_cmd_addr, and clear beat_cnt to 0.
REQ-013 wr_cmd_start SHALL be ignored outside IDLE, and ignored when wr_cmd_bl=0.
REQ-014 app_cmd SHALL be the constant 3'b000 (write).
REQ-015 app_wdf_mask SHALL be the constant 16'h0000.
REQ-016 app_wdf_data SHALL be wr_data_128bit, passed through combinationally.
REQ-017 app_wdf_end SHALL equal app_wdf_wren (one 128-bit beat is one BL8 burst).
REQ-018 In WRITE, the handshake outputs SHALL be:
- app_en = app_wdf_rdy.
- app_wdf_wren = app_rdy.
- Both are 0 in other states.
REQ-019 A beat SHALL fire when state=WRITE && app_rdy && app_wdf_rdy; wr_data_req SHALL equal fire (combinational, no latency).
REQ-020 Each fire SHALL:
- add 8 to the address register, wrapping modulo 2^28 with no error;
- increment beat_cnt.
REQ-021 The last beat SHALL be the fire with beat_cnt == cmd_bl-1.
REQ-022 app_addr SHALL be the address register, which holds the address of the current beat.
REQ-023 Either ready low SHALL stall the burst, with no beat, no address change and no counter change.
REQ-024 wr_end SHALL be registered and high for exactly the DONE cycle, i.e. the cycle after the last fire.
REQ-025 A new wr_cmd_start is accepted no earlier than the cycle after DONE.
REQ-026 wr_busy SHALL be high in WRITE and DONE.
REQ-027 A maximum burst of wr_cmd_bl=127 SHALL give 127 fires with a final app_addr of start+1008.

Reset
REQ-028 With rst=1 at a clock edge, the block SHALL enter IDLE and clear every register: cmd_bl, beat_cnt, address register, timeout counter, wr_end and wr_err.
REQ-029 During and after reset, all outputs SHALL read 0.
REQ-030 A reset in WRITE SHALL abort the burst immediately, without asserting wr_end or wr_err.
REQ-031 rst SHALL take priority over wr_cmd_start in the same cycle.

Configuration
REQ-032 The macro A7_DDR3_WR_TIMEOUT_EN, when defined, SHALL compile in the stall watchdog:
- A 10-bit counter runs in WRITE; it increments on each non-fire cycle and clears on each fire.
- When the counter reaches 1023 without a fire, the state goes to IDLE, wr_err pulses for 1 cycle, wr_end stays 0, and the counter clears.
REQ-033 Without A7_DDR3_WR_TIMEOUT_EN, there SHALL be no watchdog logic, wr_err SHALL be tied 0, and WRITE SHALL wait indefinitely.

Verification
REQ-034 Basic burst: start, bl=4, addr=28'h100, both readies held 1.
- Required: 4 consecutive fires, app_addr 100/108/110/118, wr_data_req high 4 cycles, wr_end pulses 1 cycle after the 4th fire.
REQ-035 Ready stalls: bl=3 with app_wdf_rdy low for 2 cycles mid-burst, and app_rdy toggling.
- Required: app_en low while app_wdf_rdy is low, no address advance during the stall, exactly 3 wr_data_req pulses in total.
REQ-036 Ignored starts: a start during WRITE, and a start with bl=0 in IDLE.
- Required: both ignored, with cmd_bl, address and wr_busy unchanged.
REQ-037 Address wrap: start, bl=2, addr=28'hFFFFFF8.
- Required: app_addr FFFFFF8 then 0000000, then wr_end.
REQ-038 Reset mid-burst: rst after 2 of 5 beats.
- Required: next cycle all outputs 0, wr_end and wr_err never pulse, and a new start with bl=1 completes normally.
REQ-039 Timeout (only with A7_DDR3_WR_TIMEOUT_EN): bl=2 with app_rdy held 0.
- Required: wr_err pulse 1023 cycles after entering WRITE, then IDLE with wr_busy=0.
- Without the macro: wr_busy stays 1 and wr_err stays 0.

Source files
------------

// File: rtl/a7_ddr3_wr_ctrl.sv
// a7_ddr3_wr_ctrl: drives bursts of 128-bit beats from an FWFT FIFO into a MIG 7-series app write port.
// Ports: sclk/rst (sync, active-high); wr_cmd_start/wr_cmd_bl/wr_cmd_addr start a burst;
//   wr_data_128bit is the FIFO head, popped by wr_data_req; wr_busy/wr_end/wr_err report status;
//   app_* connect to the MIG user interface.
// Optional: define A7_DDR3_WR_TIMEOUT_EN to add a stall watchdog that aborts a burst and pulses wr_err.
module a7_ddr3_wr_ctrl (
  input  logic         sclk,
  input  logic         rst,
  input  logic         wr_cmd_start,
  input  logic [6:0]   wr_cmd_bl,
  input  logic [27:0]  wr_cmd_addr,
  input  logic [127:0] wr_data_128bit,
  output logic         wr_data_req,
  output logic         wr_busy,
  output logic         wr_end,
  output logic         wr_err,
  input  logic         app_rdy,
  input  logic         app_wdf_rdy,
  output logic         app_en,
  output logic [27:0]  app_addr,
  output logic [2:0]   app_cmd,
  output logic         app_wdf_wren,
  output logic [127:0] app_wdf_data,
  output logic         app_wdf_end,
  output logic [15:0]  app_wdf_mask
);
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [6:0] cmd_bl_q, cmd_bl_d, beat_cnt_q, beat_cnt_d;
  logic [27:0] addr_q, addr_d;
  logic wr_end_q, wr_end_d;
  logic fire, last, tmo;
  assign fire = (state_q == WRITE) && app_rdy && app_wdf_rdy;
  assign last = fire && (beat_cnt_q == cmd_bl_q - 7'd1);
`ifdef A7_DDR3_WR_TIMEOUT_EN
  logic [9:0] tmo_q, tmo_d;
  logic wr_err_q;
  // Abort on the stalled cycle that would bring the counter to 1023.
  assign tmo   = (state_q == WRITE) && !fire && (tmo_q == 10'd1022);
  assign tmo_d = (state_q != WRITE || fire || tmo) ? 10'd0 : tmo_q + 10'd1;
  always_ff @(posedge sclk) begin
    if (rst) begin
      tmo_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      tmo_q    <= tmo_d;
      wr_err_q <= tmo;
    end
  end
  assign wr_err = wr_err_q;
`else
  assign tmo    = 1'b0;
  assign wr_err = 1'b0;
`endif
  always_comb begin
    state_d    = state_q;
    cmd_bl_d   = cmd_bl_q;
    beat_cnt_d = beat_cnt_q;
    addr_d     = addr_q;
    wr_end_d   = 1'b0;
    case (state_q)
      IDLE: if (wr_cmd_start && wr_cmd_bl != 7'd0) begin
        state_d    = WRITE;
        cmd_bl_d   = wr_cmd_bl;
        beat_cnt_d = 7'd0;
        addr_d     = wr_cmd_addr;
      end
      WRITE: begin
        if (fire) begin
          addr_d     = addr_q + 28'd8;
          beat_cnt_d = beat_cnt_q + 7'd1;
        end
        if (last) begin
          state_d  = DONE;
          wr_end_d = 1'b1;
        end else if (tmo) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_bl_q   <= '0;
      beat_cnt_q <= '0;
      addr_q     <= '0;
      wr_end_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_bl_q   <= cmd_bl_d;
      beat_cnt_q <= beat_cnt_d;
      addr_q     <= addr_d;
      wr_end_q   <= wr_end_d;
    end
  end
  assign wr_data_req  = fire;
  assign wr_busy      = state_q != IDLE;
  assign wr_end       = wr_end_q;
  assign app_en       = (state_q == WRITE) && app_wdf_rdy;
  assign app_wdf_wren = (state_q == WRITE) && app_rdy;
  assign app_wdf_end  = app_wdf_wren;
  assign app_addr     = addr_q;
  assign app_cmd      = 3'b000;
  assign app_wdf_data = wr_data_128bit;
  assign app_wdf_mask = 16'h0000;
endmodule

// File: tb/tb_a7_ddr3_wr_ctrl.sv
// tb_a7_ddr3_wr_ctrl: randomized self-checking bench for a7_ddr3_wr_ctrl against an address/beat-count model.
module tb_a7_ddr3_wr_ctrl;
  logic sclk = 1'b0, rst = 1'b1, wr_cmd_start = 1'b0;
  logic [6:0] wr_cmd_bl = '0;
  logic [27:0] wr_cmd_addr = '0;
  logic [127:0] wr_data_128bit = '0;
  logic app_rdy = 1'b0, app_wdf_rdy = 1'b0;
  logic wr_data_req, wr_busy, wr_end, wr_err, app_en, app_wdf_wren, app_wdf_end;
  logic [27:0] app_addr;
  logic [2:0] app_cmd;
  logic [127:0] app_wdf_data;
  logic [15:0] app_wdf_mask;
  logic [53:0] outs;
  int checks = 0, errors = 0;
  a7_ddr3_wr_ctrl dut (
    .sclk(sclk), .rst(rst), .wr_cmd_start(wr_cmd_start), .wr_cmd_bl(wr_cmd_bl),
    .wr_cmd_addr(wr_cmd_addr), .wr_data_128bit(wr_data_128bit), .wr_data_req(wr_data_req),
    .wr_busy(wr_busy), .wr_end(wr_end), .wr_err(wr_err), .app_rdy(app_rdy),
    .app_wdf_rdy(app_wdf_rdy), .app_en(app_en), .app_addr(app_addr), .app_cmd(app_cmd),
    .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask)
  );
  assign outs = {wr_data_req, wr_busy, wr_end, wr_err, app_en, app_addr, app_cmd,
                 app_wdf_wren, app_wdf_end, app_wdf_mask};
  always #5 sclk = ~sclk;
  task automatic tick();
    @(posedge sclk);
    #1;
  endtask
  task automatic run_burst(input int bl, input logic [27:0] addr, input int mode, output int cyc);
    int fires = 0;
    logic [27:0] exp_addr;
    logic [5:0] pa = 6'b110101;
    logic [5:0] pw = 6'b111001;
    cyc = 0;
    wr_cmd_start = 1'b1;
    wr_cmd_bl = 7'(bl);
    wr_cmd_addr = addr;
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b0;
    tick();
    wr_cmd_start = 1'b0;
    wr_cmd_bl = 7'($urandom_range(0, 127));
    wr_cmd_addr = 28'($urandom);
    while (fires < bl && cyc < 3000) begin
      app_rdy     = mode == 1 ? 1'($urandom_range(0, 1)) : mode == 2 && cyc < 6 ? pa[cyc] : 1'b1;
      app_wdf_rdy = mode == 1 ? 1'($urandom_range(0, 1)) : mode == 2 && cyc < 6 ? pw[cyc] : 1'b1;
      wr_data_128bit = {$urandom, $urandom, $urandom, $urandom};
      @(negedge sclk);
      exp_addr = addr + 28'(8 * fires);
      checks++;
      if ({wr_busy, app_en, app_wdf_wren, wr_data_req, app_wdf_end, wr_end, wr_err} !==
          {1'b1, app_wdf_rdy, app_rdy, app_rdy & app_wdf_rdy, app_rdy, 2'b00}) begin
        errors++;
        $display("FAIL burst_hs cyc=%0d got busy/en/wren/req/end/wend/err=%b%b%b%b%b%b%b rdy=%b wdf_rdy=%b",
                 cyc, wr_busy, app_en, app_wdf_wren, wr_data_req, app_wdf_end, wr_end, wr_err, app_rdy, app_wdf_rdy);
      end
      checks++;
      if (app_addr !== exp_addr) begin
        errors++;
        $display("FAIL burst_addr beat=%0d got %h expected %h", fires, app_addr, exp_addr);
      end
      checks++;
      if (app_wdf_data !== wr_data_128bit || app_cmd !== 3'b000 || app_wdf_mask !== 16'h0) begin
        errors++;
        $display("FAIL burst_const got data=%h cmd=%b mask=%h expected data=%h cmd=0 mask=0",
                 app_wdf_data, app_cmd, app_wdf_mask, wr_data_128bit);
      end
      if (app_rdy && app_wdf_rdy) fires++;
      cyc++;
      tick();
    end
    checks++;
    if (fires != bl) begin
      errors++;
      $display("FAIL burst_budget got %0d fires expected %0d", fires, bl);
    end
    @(negedge sclk);
    checks++;
    if ({wr_end, wr_busy, wr_data_req, app_en, wr_err} !== 5'b11000) begin
      errors++;
      $display("FAIL done_cycle got end/busy/req/en/err=%b%b%b%b%b expected 11000",
               wr_end, wr_busy, wr_data_req, app_en, wr_err);
    end
    tick();
    @(negedge sclk);
    checks++;
    if ({wr_end, wr_busy} !== 2'b00) begin
      errors++;
      $display("FAIL after_done got end/busy=%b%b expected 00", wr_end, wr_busy);
    end
    tick();
  endtask
  task automatic test_reset();
    rst = 1'b1;
    wr_cmd_start = 1'b1;
    wr_cmd_bl = 7'd5;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    repeat (3) tick();
    @(negedge sclk);
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outs got %h expected 0", outs);
    end
    tick();
    rst = 1'b0;
    wr_cmd_start = 1'b0;
    tick();
    @(negedge sclk);
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL post_reset_outs got %h expected 0", outs);
    end
    tick();
  endtask
  task automatic test_basic();
    int cyc;
    run_burst(4, 28'h100, 0, cyc);
    checks++;
    if (cyc != 4) begin
      errors++;
      $display("FAIL basic_cycles got %0d expected 4", cyc);
    end
  endtask
  task automatic test_stalls();
    int cyc;
    run_burst(3, 28'($urandom) & ~28'h7, 2, cyc);
    checks++;
    if (cyc != 6) begin
      errors++;
      $display("FAIL stall_cycles got %0d expected 6", cyc);
    end
    repeat (8) run_burst($urandom_range(1, 20), 28'($urandom), 1, cyc);
  endtask
  task automatic test_ignored();
    logic [27:0] prev, a;
    int fires = 0, ends = 0;
    prev = app_addr;
    wr_cmd_start = 1'b1;
    wr_cmd_bl = 7'd0;
    wr_cmd_addr = 28'h1234560;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    tick();
    wr_cmd_start = 1'b0;
    @(negedge sclk);
    checks++;
    if (wr_busy !== 1'b0 || app_addr !== prev || wr_data_req !== 1'b0) begin
      errors++;
      $display("FAIL ignore_bl0 got busy=%b addr=%h expected busy=0 addr=%h", wr_busy, app_addr, prev);
    end
    tick();
    a = 28'($urandom);
    wr_cmd_start = 1'b1;
    wr_cmd_bl = 7'd2;
    wr_cmd_addr = a;
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b0;
    tick();
    wr_cmd_start = 1'b0;
    repeat (2) tick();
    wr_cmd_start = 1'b1;
    wr_cmd_bl = 7'd7;
    wr_cmd_addr = a ^ 28'h5555550;
    tick();
    wr_cmd_start = 1'b0;
    @(negedge sclk);
    checks++;
    if (wr_busy !== 1'b1 || app_addr !== a) begin
      errors++;
      $display("FAIL ignore_busy got busy=%b addr=%h expected busy=1 addr=%h", wr_busy, app_addr, a);
    end
    tick();
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    repeat (6) begin
      @(negedge sclk);
      if (wr_data_req) begin
        checks++;
        if (app_addr !== a + 28'(8 * fires)) begin
          errors++;
          $display("FAIL ignore_addr got %h expected %h", app_addr, a + 28'(8 * fires));
        end
        fires++;
      end
      if (wr_end) ends++;
      tick();
    end
    checks++;
    if (fires != 2 || ends != 1) begin
      errors++;
      $display("FAIL ignore_count got fires=%0d ends=%0d expected 2 and 1", fires, ends);
    end
  endtask
  task automatic test_wrap_and_max();
    int cyc;
    run_burst(2, 28'hFFFFFF8, 0, cyc);
    run_burst(127, 28'h0ABCDE0, 0, cyc);
    checks++;
    if (cyc != 127) begin
      errors++;
      $display("FAIL max_cycles got %0d expected 127", cyc);
    end
  endtask
  task automatic test_reset_mid();
    int cyc, bad = 0;
    wr_cmd_start = 1'b1;
    wr_cmd_bl = 7'd5;
    wr_cmd_addr = 28'h2000;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    tick();
    wr_cmd_start = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b0;
    wr_data_128bit = '0;
    tick();
    @(negedge sclk);
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_mid_outs got %h expected 0", outs);
    end
    tick();
    rst = 1'b0;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    repeat (4) begin
      @(negedge sclk);
      if (wr_end || wr_err || wr_busy) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet got %0d active cycles expected 0", bad);
    end
    run_burst(1, 28'($urandom), 0, cyc);
  endtask
  task automatic test_timeout();
    int n = 0, bad = 0;
    wr_cmd_start = 1'b1;
    wr_cmd_bl = 7'd2;
    wr_cmd_addr = 28'h40;
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b1;
    tick();
    wr_cmd_start = 1'b0;
`ifdef A7_DDR3_WR_TIMEOUT_EN
    while (n < 1100) begin
      @(negedge sclk);
      if (wr_err) break;
      if (wr_end || !wr_busy) bad++;
      n++;
      tick();
    end
    checks++;
    if (n != 1023 || wr_busy !== 1'b0 || wr_end !== 1'b0 || bad != 0) begin
      errors++;
      $display("FAIL timeout got err_cycle=%0d busy=%b end=%b bad=%0d expected 1023 0 0 0",
               n, wr_busy, wr_end, bad);
    end
    tick();
    @(negedge sclk);
    checks++;
    if (wr_err !== 1'b0 || wr_busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_after got err=%b busy=%b expected 0 0", wr_err, wr_busy);
    end
`else
    repeat (1100) begin
      @(negedge sclk);
      if (!wr_busy || wr_err || wr_end) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL no_timeout got %0d bad cycles expected 0", bad);
    end
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask
  initial begin
    #1;
    test_reset();
    test_basic();
    test_stalls();
    test_ignored();
    test_wrap_and_max();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end
endmodule
